// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and helpers for the
// multi-ported register file and its scoreboard.
package reg_file_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 2;
   localparam int NWR_DEF   = 2;

   function automatic int calc_aw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// reg_scoreboard: per-register pending-write bits.
// Alloc sets a bit, a write clears it, alloc wins on a tie.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int NWR   = NWR_DEF,
   parameter int AW    = calc_aw(NREGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NWR-1:0]    we,
   input  logic [NWR*AW-1:0] waddr,
   input  logic              alloc_valid,
   input  logic [AW-1:0]     alloc_rd,
   output logic              alloc_ready,
   output logic [NREGS-1:0]  busy_vec
);

   logic [NREGS-1:0] clr;
   logic [NREGS-1:0] set;

   // decode write-clears and the accepted alloc
   always_comb begin
      clr = '0;
      set = '0;
      for (int i = 0; i < NWR; i++) begin
         if (we[i])
            clr[waddr[i*AW +: AW]] = 1'b1;
      end
      if (alloc_valid && alloc_ready && alloc_rd != '0)
         set[alloc_rd] = 1'b1;
      clr[0] = 1'b0;
   end

   // WAW stall when the destination is already pending
   assign alloc_ready = (alloc_rd == '0) || !busy_vec[alloc_rd];

   // busy bits: clear on write, then set on alloc
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_vec <= '0;
      else
         busy_vec <= ((busy_vec & ~clr) | set) & ~NREGS'(1);
   end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: NRD-read / NWR-write register file with
// optional write forwarding and a pending-write scoreboard.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NRD    = NRD_DEF,
   parameter int NWR    = NWR_DEF,
   parameter int BYPASS = 1,
   localparam int AW    = calc_aw(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   waddr,
   input  logic [NWR*XLEN-1:0] wdata,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rbusy,
   input  logic                alloc_valid,
   input  logic [AW-1:0]       alloc_rd,
   output logic                alloc_ready,
   output logic [NREGS-1:0]    busy_vec
);

   logic [XLEN-1:0] regs [NREGS];
   logic [AW-1:0]   ra;
   logic [XLEN-1:0] rval;
   logic            rb;

   reg_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR),
      .AW    (AW)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .we          (we),
      .waddr       (waddr),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_rd),
      .alloc_ready (alloc_ready),
      .busy_vec    (busy_vec)
   );

   // storage: later (higher) ports overwrite earlier ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= '0;
      end else begin
         for (int i = 0; i < NWR; i++) begin
            if (we[i] && waddr[i*AW +: AW] != '0)
               regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
         end
      end
   end

   // read ports with forwarding; x0 and reset force zero
   always_comb begin
      rdata = '0;
      rbusy = '0;
      ra    = '0;
      rval  = '0;
      rb    = 1'b0;
      for (int j = 0; j < NRD; j++) begin
         ra   = raddr[j*AW +: AW];
         rval = regs[ra];
         rb   = busy_vec[ra];
         if (BYPASS != 0) begin
            for (int i = 0; i < NWR; i++) begin
               if (we[i] && waddr[i*AW +: AW] == ra) begin
                  rval = wdata[i*XLEN +: XLEN];
                  rb   = 1'b0;
               end
            end
         end
         if (ra == '0 || !rst_n) begin
            rval = '0;
            rb   = 1'b0;
         end
         rdata[j*XLEN +: XLEN] = rval;
         rbusy[j]              = rb;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks on a forwarding and a
// non-forwarding instance driven by the same stimulus.
module tb_reg_file_mp;

   localparam int XL = 32;
   localparam int NR = 32;
   localparam int AW = 5;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     we;
   logic [2*AW-1:0] waddr;
   logic [2*XL-1:0] wdata;
   logic [2*AW-1:0] raddr;
   logic           alloc_valid;
   logic [AW-1:0]  alloc_rd;

   logic [2*XL-1:0] rdata_b, rdata_n;
   logic [1:0]      rbusy_b, rbusy_n;
   logic            ready_b, ready_n;
   logic [NR-1:0]   busy_b, busy_n;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg_file_mp #(.BYPASS(1)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .raddr       (raddr),
      .rdata       (rdata_b),
      .rbusy       (rbusy_b),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_rd),
      .alloc_ready (ready_b),
      .busy_vec    (busy_b)
   );

   reg_file_mp #(.BYPASS(0)) dut_n (
      .clk         (clk),
      .rst_n       (rst_n),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .raddr       (raddr),
      .rdata       (rdata_n),
      .rbusy       (rbusy_n),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_rd),
      .alloc_ready (ready_n),
      .busy_vec    (busy_n)
   );

   task automatic check(input string tag,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int p, input int a,
                     input logic [31:0] d);
      we[p]             = 1'b1;
      waddr[p*AW +: AW] = AW'(a);
      wdata[p*XL +: XL] = d;
   endtask

   task automatic rd(input int p, input int a);
      raddr[p*AW +: AW] = AW'(a);
   endtask

   task automatic idle();
      we          = '0;
      alloc_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      we          = '0;
      waddr       = '0;
      wdata       = '0;
      raddr       = '0;
      alloc_valid = 1'b0;
      alloc_rd    = '0;
      #3;
      rd(0, 5);
      rd(1, 7);
      #1;
      check("rst_rd0", rdata_b[31:0], 0);
      check("rst_busy", busy_b, 0);
      check("rst_ready", ready_b, 1);
      #3 rst_n = 1'b1;

      // x5 write, forwarded vs stored
      wr(0, 5, 32'hDEADBEEF);
      #1;
      check("x5_fwd_b", rdata_b[31:0], 32'hDEADBEEF);
      check("x5_fwd_n", rdata_n[31:0], 0);
      tick();
      idle();
      #1;
      check("x5_rd_b", rdata_b[31:0], 32'hDEADBEEF);
      check("x5_rd_n", rdata_n[31:0], 32'hDEADBEEF);

      // x0 is hardwired
      wr(0, 0, 32'h1234);
      rd(0, 0);
      #1;
      check("x0_fwd_b", rdata_b[31:0], 0);
      tick();
      idle();
      #1;
      check("x0_rd_b", rdata_b[31:0], 0);
      check("x0_rd_n", rdata_n[31:0], 0);

      // two ports to x7, port 1 wins
      wr(0, 7, 32'h11);
      wr(1, 7, 32'h22);
      #1;
      check("x7_fwd_b", rdata_b[63:32], 32'h22);
      check("x7_fwd_n", rdata_n[63:32], 0);
      tick();
      idle();
      #1;
      check("x7_rd_b", rdata_b[63:32], 32'h22);
      check("x7_rd_n", rdata_n[63:32], 32'h22);

      // x3: old value, mark busy, then forwarded write
      wr(0, 3, 32'h5A);
      tick();
      idle();
      alloc_valid = 1'b1;
      alloc_rd    = 5'd3;
      #1;
      check("x3_ready", ready_b, 1);
      tick();
      idle();
      #1;
      check("x3_busy", busy_b[3], 1);
      wr(1, 3, 32'hA5);
      rd(0, 3);
      #1;
      check("x3_fwd_b", rdata_b[31:0], 32'hA5);
      check("x3_rb_b", rbusy_b[0], 0);
      check("x3_old_n", rdata_n[31:0], 32'h5A);
      check("x3_rb_n", rbusy_n[0], 1);
      tick();
      idle();
      #1;
      check("x3_clr", busy_b, 0);
      check("x3_rd_n", rdata_n[31:0], 32'hA5);

      // x9 scoreboard: alloc, stall, clear, tie
      alloc_valid = 1'b1;
      alloc_rd    = 5'd9;
      tick();
      idle();
      rd(1, 9);
      #1;
      check("x9_busy", busy_b, 32'h200);
      check("x9_stall", ready_b, 0);
      check("x9_rbusy", rbusy_n[1], 1);
      alloc_valid = 1'b1;
      tick();
      idle();
      #1;
      check("x9_hold", busy_n, 32'h200);
      wr(0, 9, 32'h99);
      tick();
      idle();
      #1;
      check("x9_wclr", busy_b, 0);
      check("x9_ready", ready_b, 1);
      alloc_valid = 1'b1;
      wr(1, 9, 32'h77);
      tick();
      idle();
      #1;
      check("x9_tie_busy", busy_b, 32'h200);
      check("x9_tie_data", rdata_n[63:32], 32'h77);
      alloc_rd    = 5'd0;
      alloc_valid = 1'b1;
      #1;
      check("x0_ready", ready_b, 1);
      tick();
      idle();
      #1;
      check("x0_alloc", busy_n, 32'h200);

      // fill x1..x31, mark x4, then async reset pulse
      for (int r = 1; r < 32; r += 2) begin
         wr(0, r, 32'h01010101 * r);
         if (r + 1 < 32)
            wr(1, r + 1, 32'h01010101 * (r + 1));
         tick();
         idle();
      end
      alloc_valid = 1'b1;
      alloc_rd    = 5'd4;
      tick();
      idle();
      rd(0, 31);
      rd(1, 4);
      #1;
      check("fill_x31", rdata_n[31:0], 32'h1F1F1F1F);
      check("fill_x4", rdata_b[63:32], 32'h04040404);
      check("fill_busy", busy_b, 32'h10);
      wr(0, 31, 32'hCAFEF00D);
      #1 rst_n = 1'b0;
      #1;
      check("prst_rd_b", rdata_b, 0);
      check("prst_rd_n", rdata_n, 0);
      check("prst_busy", busy_b, 0);
      check("prst_ready", ready_b, 1);
      idle();
      #1 rst_n = 1'b1;
      #1;
      check("post_x31", rdata_b[31:0], 0);
      check("post_x4", rdata_n[63:32], 0);
      tick();
      #1;
      check("post_busy", busy_n, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, as the following ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
we  input  NWR  write enable per write port
waddr  input  NWR*AW  write address per port, port i in bits [i*AW +: AW]
wdata  input  NWR*XLEN  write data per port
raddr  input  NRD*AW  read address per port
rdata  output  NRD*XLEN  read data per port, combinational
rbusy  output  NRD  pending-write flag for each read address
alloc_valid  input  1  request to mark destination alloc_rd as pending
alloc_rd  input  AW  destination register to mark
alloc_ready  output  1  alloc_rd may be marked this cycle
busy_vec  output  NREGS  scoreboard state, bit r = register r pending

Function
REQ-007 Register 0 SHALL always read 0, never be written, and never be busy; writes and allocs to address 0 are ignored.
REQ-008 A write on port i with we[i]=1 and waddr!=0 SHALL update the register at the next rising clk.
REQ-009 When several write ports target the same register in one cycle, the highest-index port SHALL win.
REQ-010 rdata SHALL be combinational from raddr; with BYPASS=1, a same-cycle write to raddr SHALL be forwarded (highest-index matching port); with BYPASS=0, the stored value SHALL be returned.
REQ-011 A write to register r SHALL clear busy[r] at the next edge.
REQ-012 alloc_ready SHALL be 1 when alloc_rd==0 or busy[alloc_rd]==0; otherwise 0 (WAW stall).
REQ-013 alloc_valid && alloc_ready && alloc_rd!=0 SHALL set busy[alloc_rd] at the next edge.
REQ-014 Simultaneous alloc and write to the same register SHALL leave busy set (alloc wins); the write data SHALL still be stored.
REQ-015 rbusy[j] SHALL equal busy[raddr_j], except that with BYPASS=1 it SHALL be 0 when a same-cycle write targets raddr_j; it SHALL always be 0 for address 0.
REQ-016 busy_vec SHALL reflect registered scoreboard state only, with no forwarding.
REQ-017 Writing a register that is not busy SHALL be legal: data is stored and busy stays 0.

Reset
REQ-018 rst_n low SHALL immediately, without a clock, clear all registers to 0 and all busy bits to 0.
REQ-019 During reset, rdata SHALL read 0 on every port, with no forwarding, and alloc_ready SHALL be 1.
REQ-020 Writes and allocs presented while rst_n is low SHALL be discarded; deassertion SHALL be synchronised by the instantiating level.

Structure
REQ-021 Package reg_file_pkg SHALL hold the default XLEN, NREGS, NRD and NWR constants and the AW derivation function.
REQ-022 Scoreboard logic SHALL be one sub-module, reg_scoreboard (busy bits, alloc_ready, clear-on-write).
REQ-023 The storage array SHALL use no reset-dependent read path other than REQ-019.

Verification
REQ-024 Write x5=0xDEADBEEF on port 0, read x5 next cycle -> rdata=0xDEADBEEF; read x0 after writing x0=0x1234 -> 0.
REQ-025 Port 0 writes x7=0x11 and port 1 writes x7=0x22 in the same cycle -> x7 reads 0x22 (same cycle with BYPASS=1, next cycle in both modes).
REQ-026 BYPASS=1: write x3=0xA5 and read x3 in the same cycle -> rdata=0xA5 and rbusy=0; BYPASS=0 -> the old value.
REQ-027 Alloc x9 -> busy_vec[9]=1 and alloc_ready=0 for alloc_rd=9; write x9 -> busy_vec[9]=0 next cycle; alloc x9 together with a write to x9 -> busy stays 1.
REQ-028 Fill x1..x31 with nonzero values and mark x4 busy, then pulse rst_n low between clock edges -> all rdata=0 and busy_vec=0 immediately.
